// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) behind a valid/ready skid buffer.
// Optional beat/stall counters are enabled by defining IMM_EXT_STATS_EN.

module imm_ext_core #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] res
);
    logic [OUT_W-1:0] sext;

    always_comb begin
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        res  = sext;
        case (mode)
            2'b00: res = sext;
            2'b01: res = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b10: res = {imm, {(OUT_W-IN_W){1'b0}}};
            2'b11: res = {sext[OUT_W-3:0], 2'b00};
            default: res = sext;
        endcase
    end
endmodule

module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_res,
`ifdef IMM_EXT_STATS_EN
    output logic [15:0]      beat_cnt,
    output logic [15:0]      stall_cnt,
`endif
    output logic [1:0]       out_mode
);
    if (IN_W < 2) begin : g_bad_in_w
        $error("imm_ext_pipe: IN_W must be >= 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("imm_ext_pipe: OUT_W must be >= IN_W+2");
    end

    typedef struct packed {
        logic [1:0]       mode;
        logic [OUT_W-1:0] res;
    } beat_t;

    beat_t            in_beat, out_q, skid_q;
    logic             out_vld, skid_vld;
    logic [OUT_W-1:0] ext_res;
    logic             acc, pop;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .res  (ext_res)
    );

    assign in_beat   = '{mode: in_mode, res: ext_res};
    assign in_ready  = !skid_vld;
    assign acc       = in_valid && in_ready;
    assign pop       = out_vld && out_ready;
    assign out_valid = out_vld;
    assign out_res   = out_q.res;
    assign out_mode  = out_q.mode;

    // Skid only fills when the output register is held; it drains first so order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (acc) begin
                out_q   <= in_beat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (acc) begin
            skid_q   <= in_beat;
            skid_vld <= 1'b1;
        end
    end

`ifdef IMM_EXT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop)
                beat_cnt <= beat_cnt + 16'd1;
            if (out_vld && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed + scoreboarded random bench for imm_ext_pipe (IN_W=16, OUT_W=32).
// Counter checks are compiled only when IMM_EXT_STATS_EN is defined.

module tb_imm_ext_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic [1:0]  out_mode;
`ifdef IMM_EXT_STATS_EN
    logic [15:0] beat_cnt, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
`ifdef IMM_EXT_STATS_EN
        .beat_cnt  (beat_cnt),
        .stall_cnt (stall_cnt),
`endif
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
        int s;
        s = int'($signed(imm));
        case (m)
            2'd0:    return 32'(s);
            2'd1:    return {16'h0000, imm};
            2'd2:    return {imm, 16'h0000};
            default: return 32'(s * 4);
        endcase
    endfunction

    logic [15:0] t1_imm [7];
    logic [1:0]  t1_mode[7];
    logic [31:0] t1_exp [7];
    logic [15:0] t2_imm [8];
    logic [1:0]  t2_mode[8];
    logic [31:0] t2_exp [8];

    initial begin
        t1_imm  = '{16'h7777, 16'h8888, 16'h8888, 16'h1234, 16'hFFFF, 16'h8000, 16'h0001};
        t1_mode = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        t1_exp  = '{32'h00007777, 32'hFFFF8888, 32'h00008888, 32'h12340000,
                    32'hFFFFFFFC, 32'hFFFE0000, 32'h00000004};
        t2_imm  = '{16'h0001, 16'hFFFE, 16'hABCD, 16'h00FF, 16'h7FFF, 16'h4000, 16'hC000, 16'h8001};
        t2_mode = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        t2_exp  = '{32'h00000001, 32'hFFFFFFFE, 32'h0000ABCD, 32'h00FF0000,
                    32'h0001FFFC, 32'h00004000, 32'h0000C000, 32'h80010000};

        // reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_res",   64'(out_res),   64'd0);
        chk("rst_out_mode",  64'(out_mode),  64'd0);
`ifdef IMM_EXT_STATS_EN
        chk("rst_beat_cnt",  64'(beat_cnt),  64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // 1: single beats with an idle cycle between them
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_imm = t1_imm[i]; in_mode = t1_mode[i];
            chk("t1_in_ready", 64'(in_ready), 64'd1);
            step();
            in_valid = 1'b0;
            chk("t1_out_valid", 64'(out_valid), 64'd1);
            chk("t1_out_res",   64'(out_res),   64'(t1_exp[i]));
            chk("t1_out_mode",  64'(out_mode),  64'(t1_mode[i]));
            step();
            chk("t1_drained", 64'(out_valid), 64'd0);
        end

        // 2: back-to-back stream
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_imm = t2_imm[i]; in_mode = t2_mode[i];
            chk("t2_in_ready", 64'(in_ready), 64'd1);
            step();
            chk("t2_out", 64'({out_valid, out_mode, out_res}), 64'({1'b1, t2_mode[i], t2_exp[i]}));
        end
        in_valid = 1'b0;
        step();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // 3: backpressure fills the skid and holds the third beat off
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h1111; in_mode = 2'd0;
        step();
        chk("t3_rdy_after1", 64'(in_ready), 64'd1);
        chk("t3_res_a",      64'(out_res),  64'h00001111);
        in_imm = 16'h9999; in_mode = 2'd0;
        step();
        chk("t3_rdy_after2", 64'(in_ready), 64'd0);
        chk("t3_hold_a1",    64'(out_res),  64'h00001111);
        in_imm = 16'h2222; in_mode = 2'd2;
        step();
        chk("t3_rdy_held",   64'(in_ready), 64'd0);
        chk("t3_hold_a2",    64'(out_res),  64'h00001111);
        step();
        chk("t3_hold_a3",    64'({out_valid, out_res}), 64'({1'b1, 32'h00001111}));
        out_ready = 1'b1;
        step();
        chk("t3_out_b",      64'({out_valid, out_res}), 64'({1'b1, 32'hFFFF9999}));
        chk("t3_rdy_back",   64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("t3_out_c",      64'({out_valid, out_mode, out_res}), 64'({1'b1, 2'd2, 32'h22220000}));
        step();
        chk("t3_drained",    64'(out_valid), 64'd0);
`ifdef IMM_EXT_STATS_EN
        chk("t6_beat_cnt",   64'(beat_cnt),  64'd3);
        chk("t6_stall_cnt",  64'(stall_cnt), 64'd3);
`endif

        // 4: random valid/ready with a scoreboard
        begin
            logic [33:0] q[$];
            logic [33:0] last, exp_b;
            logic        pend, stall_prev, acc, pop;
            int          popped, cyc;
            pend = 1'b0; stall_prev = 1'b0; popped = 0; cyc = 0; last = '0;
            while (popped < 2000 && cyc < 20000) begin
                if (!pend) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_imm   = 16'($urandom);
                    in_mode  = 2'($urandom_range(0, 3));
                end
                out_ready = 1'($urandom_range(0, 1));
                if (stall_prev)
                    chk("t4_stable", 64'({out_valid, out_mode, out_res}), 64'({1'b1, last}));
                acc = in_valid && in_ready;
                pop = out_valid && out_ready;
                if (pop) begin
                    exp_b = (q.size() > 0) ? q.pop_front() : 34'h3_DEAD_BEEF;
                    chk("t4_beat", 64'({out_mode, out_res}), 64'(exp_b));
                    popped++;
                end
                if (acc)
                    q.push_back({in_mode, ref_ext(in_imm, in_mode)});
                pend       = in_valid && !acc;
                stall_prev = out_valid && !out_ready;
                last       = {out_mode, out_res};
                step();
                cyc++;
            end
            if (popped < 2000)
                chk("t4_timeout", 64'(popped), 64'd2000);
            in_valid = 1'b0;
            out_ready = 1'b1;
            step();
            step();
        end

        // 5: asynchronous reset while both entries are full
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h5555; in_mode = 2'd1;
        step();
        in_imm = 16'h6666;
        step();
        in_valid = 1'b0;
        chk("t5_two_state", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_ready", 64'(in_ready),  64'd1);
        step();
        #2 rst_n = 1'b1;
        step();
        chk("t5_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_imm = 16'h00FF; in_mode = 2'd0;
        step();
        in_valid = 1'b0;
        chk("t5_first", 64'({out_valid, out_mode, out_res}), 64'({1'b1, 2'd0, 32'h000000FF}));
        step();

`ifdef IMM_EXT_STATS_EN
        // 6: stall saturation and beat counter wrap
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0042; in_mode = 2'd0;
        step();
        in_valid = 1'b0;
        repeat (65540) step();
        chk("t6_stall_sat", 64'(stall_cnt), 64'hFFFF);
        force dut.beat_cnt = 16'hFFFF;
        #1;
        release dut.beat_cnt;
        out_ready = 1'b1;
        step();
        chk("t6_beat_wrap", 64'(beat_cnt), 64'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
